// File: rtl/dpi_stream_sequencer_if.sv
// Ingress packet beat stream: key on the sop beat, valid/ready handshake per byte.
interface dpi_stream_sequencer_if #(
    parameter int KEY_W = 32
);
    logic [7:0]       in_data;
    logic [KEY_W-1:0] in_key;
    logic             in_vld;
    logic             in_sop;
    logic             in_eop;
    logic             in_ready;

    modport master (output in_data, in_key, in_vld, in_sop, in_eop, input in_ready);
    modport slave  (input in_data, in_key, in_vld, in_sop, in_eop, output in_ready);
endinterface

// File: rtl/dpi_stream_sequencer.sv
// Resolves flow key to stream id, then drives load/char/eop to the matcher bank.
// sop->load_state = lookup+1 cycles; ingress stalls until STREAM, stray beats in IDLE are dropped.
module dpi_stream_sequencer #(
    parameter int NUM_STREAMS = 64,
    parameter int KEY_W       = 32,
    parameter int NUM_REGEX   = 8,
    parameter int LOAD_GAP    = 2,
    parameter int EOP_GAP     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    dpi_stream_sequencer_if.slave  ing,
    input  logic                   cfg_we,
    input  logic [5:0]             cfg_addr,
    input  logic [NUM_REGEX-1:0]   cfg_data,
    output logic                   load_state,
    output logic                   new_stream_id,
    output logic [5:0]             stream_id,
    output logic [NUM_REGEX-1:0]   enable,
    output logic [7:0]             char_in,
    output logic                   char_in_vld,
    output logic                   eop,
    output logic [15:0]            drop_count
);
    localparam int ID_W = $clog2(NUM_STREAMS);
    localparam logic [ID_W:0] FULL = (ID_W+1)'(NUM_STREAMS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP
    } state_t;

    state_t               state, state_n;
    logic [KEY_W-1:0]     key_q;
    logic [KEY_W-1:0]     tbl_key [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] tbl_vld;
    logic [NUM_REGEX-1:0] en_table [NUM_STREAMS];
    logic [ID_W:0]        scan_idx, valid_cnt;
    logic [ID_W-1:0]      scan_ptr, alloc_ptr;
    logic                 new_q;
    logic [7:0]           gap_cnt;
    logic                 scan_end, hit, accept;

    assign scan_ptr      = scan_idx[ID_W-1:0];
    assign scan_end      = (scan_idx == valid_cnt);
    assign hit           = ~scan_end & tbl_vld[scan_ptr] & (tbl_key[scan_ptr] == key_q);
    assign accept        = ing.in_vld & ing.in_ready;
    assign load_state    = (state == S_LOAD);
    assign new_stream_id = load_state & new_q;
    assign eop           = (state == S_EOP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // The LOAD cycle counts as the first gap cycle, so LOAD_GAP == 2 skips GAP entirely.
    always_comb begin
        state_n      = state;
        ing.in_ready = 1'b0;
        case (state)
            S_IDLE: begin
                ing.in_ready = ing.in_vld & ~ing.in_sop;
                if (ing.in_vld & ing.in_sop) state_n = S_LOOKUP;
            end
            S_LOOKUP: if (hit | scan_end) state_n = S_LOAD;
            S_LOAD:   state_n = (LOAD_GAP > 2) ? S_GAP : S_STREAM;
            S_GAP:    if (gap_cnt == 8'd0) state_n = S_STREAM;
            S_STREAM: begin
                ing.in_ready = 1'b1;
                if (ing.in_vld & ing.in_eop) state_n = S_DRAIN;
            end
            S_DRAIN:  if (gap_cnt == 8'd0) state_n = S_EOP;
            S_EOP:    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q       <= '0;
            tbl_vld     <= '0;
            scan_idx    <= '0;
            valid_cnt   <= '0;
            alloc_ptr   <= '0;
            new_q       <= 1'b0;
            stream_id   <= '0;
            enable      <= '0;
            gap_cnt     <= '0;
            char_in     <= '0;
            char_in_vld <= 1'b0;
            drop_count  <= '0;
        end else begin
            char_in_vld <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ing.in_vld & ing.in_sop) begin
                        key_q    <= ing.in_key;
                        scan_idx <= '0;
                    end else if (ing.in_vld && drop_count != 16'hFFFF) begin
                        drop_count <= drop_count + 16'd1;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        stream_id <= scan_ptr;
                        new_q     <= 1'b0;
                    end else if (scan_end) begin
                        // alloc_ptr wraps naturally, giving oldest-first replacement once full
                        tbl_vld[alloc_ptr] <= 1'b1;
                        stream_id          <= alloc_ptr;
                        new_q              <= 1'b1;
                        alloc_ptr          <= alloc_ptr + 1'b1;
                        if (valid_cnt != FULL) valid_cnt <= valid_cnt + 1'b1;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                S_LOAD: begin
                    enable  <= en_table[stream_id];
                    gap_cnt <= 8'(LOAD_GAP - 3);
                end
                S_GAP, S_DRAIN: gap_cnt <= gap_cnt - 8'd1;
                S_STREAM: begin
                    if (accept) begin
                        char_in     <= ing.in_data;
                        char_in_vld <= 1'b1;
                        if (ing.in_eop) gap_cnt <= 8'(EOP_GAP - 1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_LOOKUP && scan_end) tbl_key[alloc_ptr] <= key_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STREAMS; i++) en_table[i] <= '1;
        end else if (cfg_we) begin
            en_table[cfg_addr] <= cfg_data;
        end
    end
endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: lookup, timing gaps, enable latching, drops, reset, wrap.
module tb_dpi_stream_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [5:0] cfg_addr = '0;
    logic [7:0] cfg_data = '0;
    logic       load_state, new_stream_id, char_in_vld, eop;
    logic [5:0] stream_id;
    logic [7:0] enable, char_in;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    dpi_stream_sequencer_if #(.KEY_W(32)) ing ();

    dpi_stream_sequencer dut (
        .clk(clk), .rst(rst), .ing(ing),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .load_state(load_state), .new_stream_id(new_stream_id), .stream_id(stream_id),
        .enable(enable), .char_in(char_in), .char_in_vld(char_in_vld), .eop(eop),
        .drop_count(drop_count)
    );

    int n_vec = 0, n_miss = 0, cyc = 0;
    int sop_cyc, load_cyc, eop_cyc, n_load, n_eop, nch, both;
    logic       ld_new;
    logic [5:0] ld_sid;
    logic [7:0] eop_en;
    int         ch_cyc [16];
    logic [7:0] ch_dat [16];
    logic [7:0] ch_en  [16];
    logic [7:0] pb [8];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (load_state) begin load_cyc = cyc; ld_new = new_stream_id; ld_sid = stream_id; n_load++; end
        if (char_in_vld && nch < 16) begin ch_cyc[nch] = cyc; ch_dat[nch] = char_in; ch_en[nch] = enable; nch++; end
        if (eop) begin eop_cyc = cyc; eop_en = enable; n_eop++; end
        if (load_state && eop) both++;
    end

    task automatic clr_mon();
        n_load = 0; n_eop = 0; nch = 0;
    endtask

    task automatic drive_pkt(input logic [31:0] key, input int n, input bit toggle);
        int i = 0, guard = 0;
        bit gap = 0, acc, first = 1;
        while (i < n && guard < 400) begin
            if (gap) ing.in_vld = 1'b0;
            else begin
                ing.in_vld = 1'b1; ing.in_sop = (i == 0); ing.in_eop = (i == n-1);
                ing.in_data = pb[i]; ing.in_key = key;
            end
            @(negedge clk);
            if (first) begin sop_cyc = cyc; first = 0; end
            acc = ing.in_vld && ing.in_ready;
            @(posedge clk); #1;
            if (acc) begin i++; gap = toggle; end else gap = 0;
            guard++;
        end
        ing.in_vld = 1'b0; ing.in_sop = 1'b0; ing.in_eop = 1'b0;
        n_vec++; if (i != n) begin n_miss++; $display("FAIL pkt_accept key=%h beats got=%0d exp=%0d", key, i, n); end
    endtask

    task automatic wait_eop();
        int g = 0;
        while (n_eop == 0 && g < 200) begin @(posedge clk); g++; end
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (n_eop != 1) begin n_miss++; $display("FAIL eop_count got=%0d exp=1", n_eop); end
    endtask

    task automatic one_pkt(input logic [31:0] key, input int n);
        clr_mon(); drive_pkt(key, n, 1'b0); wait_eop();
    endtask

    task automatic test_reset();
        ing.in_vld = 0; ing.in_sop = 0; ing.in_eop = 0; ing.in_data = '0; ing.in_key = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++; if ({load_state, new_stream_id, eop, char_in_vld, ing.in_ready} !== 5'b0) begin n_miss++; $display("FAIL rst_ctrl got=%b exp=00000", {load_state, new_stream_id, eop, char_in_vld, ing.in_ready}); end
        n_vec++; if (stream_id !== 6'd0) begin n_miss++; $display("FAIL rst_sid got=%0d exp=0", stream_id); end
        n_vec++; if (enable !== 8'h00) begin n_miss++; $display("FAIL rst_enable got=%h exp=00", enable); end
        n_vec++; if ({char_in, drop_count} !== 24'd0) begin n_miss++; $display("FAIL rst_data got=%h exp=0", {char_in, drop_count}); end
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_first_packet();
        pb[0] = 8'h61; pb[1] = 8'h62; pb[2] = 8'h63; both = 0;
        one_pkt(32'hA5A5A5A5, 3);
        n_vec++; if (n_load !== 1) begin n_miss++; $display("FAIL first_nload got=%0d exp=1", n_load); end
        n_vec++; if ({ld_new, ld_sid} !== {1'b1, 6'd0}) begin n_miss++; $display("FAIL first_new_sid got=%b/%0d exp=1/0", ld_new, ld_sid); end
        n_vec++; if (load_cyc - sop_cyc !== 2) begin n_miss++; $display("FAIL first_sop2load got=%0d exp=2", load_cyc - sop_cyc); end
        n_vec++; if (nch !== 3) begin n_miss++; $display("FAIL first_nchar got=%0d exp=3", nch); end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (ch_cyc[i] - load_cyc !== 2 + i) begin n_miss++; $display("FAIL first_char_time[%0d] got=%0d exp=%0d", i, ch_cyc[i] - load_cyc, 2 + i); end
        end
        n_vec++; if ({ch_dat[0], ch_dat[1], ch_dat[2]} !== 24'h616263) begin n_miss++; $display("FAIL first_chars got=%h exp=616263", {ch_dat[0], ch_dat[1], ch_dat[2]}); end
        n_vec++; if (eop_cyc - ch_cyc[2] !== 4) begin n_miss++; $display("FAIL first_eop_gap got=%0d exp=4", eop_cyc - ch_cyc[2]); end
        n_vec++; if (eop_en !== 8'hFF) begin n_miss++; $display("FAIL first_enable got=%h exp=ff", eop_en); end
        n_vec++; if (both !== 0) begin n_miss++; $display("FAIL first_load_eop_overlap got=%0d exp=0", both); end
    endtask

    task automatic test_hit();
        logic [31:0] keys [3] = '{32'h11111111, 32'h22222222, 32'hA5A5A5A5};
        logic [5:0]  esid [3] = '{6'd1, 6'd2, 6'd0};
        logic        enew [3] = '{1'b1, 1'b1, 1'b0};
        int          elat [3] = '{3, 4, 2};
        pb[0] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            one_pkt(keys[k], 1);
            n_vec++; if ({ld_new, ld_sid} !== {enew[k], esid[k]}) begin n_miss++; $display("FAIL hit_sid[%0d] got=%b/%0d exp=%b/%0d", k, ld_new, ld_sid, enew[k], esid[k]); end
            n_vec++; if (load_cyc - sop_cyc !== elat[k]) begin n_miss++; $display("FAIL hit_latency[%0d] got=%0d exp=%0d", k, load_cyc - sop_cyc, elat[k]); end
        end
    endtask

    task automatic test_enable();
        cfg_we = 1; cfg_addr = 6'd3; cfg_data = 8'h05;
        @(posedge clk); #1; cfg_we = 0;
        pb[0] = 8'h10; pb[1] = 8'h11; pb[2] = 8'h12; pb[3] = 8'h13;
        clr_mon();
        fork
            drive_pkt(32'h33333333, 4, 1'b0);
            begin
                int g = 0;
                while (n_load == 0 && g < 200) begin @(negedge clk); g++; end
                @(posedge clk); #1; cfg_we = 1; cfg_addr = 6'd3; cfg_data = 8'h00;
                @(posedge clk); #1; cfg_we = 0;
            end
        join
        wait_eop();
        n_vec++; if ({ld_new, ld_sid} !== {1'b1, 6'd3}) begin n_miss++; $display("FAIL en_sid got=%b/%0d exp=1/3", ld_new, ld_sid); end
        n_vec++; if (ch_en[0] !== 8'h05) begin n_miss++; $display("FAIL en_first_char got=%h exp=05", ch_en[0]); end
        n_vec++; if (eop_en !== 8'h05) begin n_miss++; $display("FAIL en_held_to_eop got=%h exp=05", eop_en); end
        clr_mon();
        fork
            drive_pkt(32'h33333333, 1, 1'b0);
            begin
                int g = 0;
                while (!load_state && g < 200) begin @(negedge clk); g++; end
                cfg_we = 1; cfg_addr = 6'd3; cfg_data = 8'h0A;
                @(posedge clk); #1; cfg_we = 0;
            end
        join
        wait_eop();
        n_vec++; if ({ld_new, ld_sid} !== {1'b0, 6'd3}) begin n_miss++; $display("FAIL en_hit_sid got=%b/%0d exp=0/3", ld_new, ld_sid); end
        n_vec++; if (eop_en !== 8'h00) begin n_miss++; $display("FAIL en_load_cycle_write got=%h exp=00", eop_en); end
        one_pkt(32'h33333333, 1);
        n_vec++; if (eop_en !== 8'h0A) begin n_miss++; $display("FAIL en_next_packet got=%h exp=0a", eop_en); end
    endtask

    task automatic test_backpressure();
        pb[0] = 8'hD0; pb[1] = 8'hD1; pb[2] = 8'hD2; pb[3] = 8'hD3;
        clr_mon(); drive_pkt(32'h44444444, 4, 1'b1); wait_eop();
        n_vec++; if ({ld_new, ld_sid} !== {1'b1, 6'd4}) begin n_miss++; $display("FAIL bp_sid got=%b/%0d exp=1/4", ld_new, ld_sid); end
        n_vec++; if (nch !== 4) begin n_miss++; $display("FAIL bp_nchar got=%0d exp=4", nch); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (ch_cyc[i] - load_cyc !== 2 + 2*i || ch_dat[i] !== 8'hD0 + 8'(i)) begin n_miss++; $display("FAIL bp_char[%0d] got=+%0d/%h exp=+%0d/%h", i, ch_cyc[i] - load_cyc, ch_dat[i], 2 + 2*i, 8'hD0 + 8'(i)); end
        end
        n_vec++; if (eop_cyc - ch_cyc[3] !== 4) begin n_miss++; $display("FAIL bp_eop_gap got=%0d exp=4", eop_cyc - ch_cyc[3]); end
    endtask

    task automatic test_drop();
        clr_mon();
        n_vec++; if (drop_count !== 16'd0) begin n_miss++; $display("FAIL drop_before got=%0d exp=0", drop_count); end
        ing.in_vld = 1; ing.in_sop = 0; ing.in_eop = 0; ing.in_data = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_vec++; if (ing.in_ready !== 1'b1) begin n_miss++; $display("FAIL drop_ready[%0d] got=%b exp=1", i, ing.in_ready); end
            @(posedge clk); #1;
        end
        ing.in_vld = 0;
        repeat (3) @(posedge clk); #1;
        n_vec++; if (drop_count !== 16'd3) begin n_miss++; $display("FAIL drop_count got=%0d exp=3", drop_count); end
        n_vec++; if (n_load !== 0) begin n_miss++; $display("FAIL drop_no_load got=%0d exp=0", n_load); end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        clr_mon();
        ing.in_vld = 1; ing.in_sop = 1; ing.in_eop = 0; ing.in_key = 32'h44444444; ing.in_data = 8'hE0;
        @(negedge clk);
        while (!char_in_vld && g < 50) begin @(negedge clk); g++; end
        n_vec++; if (char_in_vld !== 1'b1) begin n_miss++; $display("FAIL rmid_reach_stream got=%b exp=1", char_in_vld); end
        rst = 1'b1; #1;
        n_vec++; if ({char_in_vld, load_state, eop, ing.in_ready} !== 4'b0) begin n_miss++; $display("FAIL rmid_ctrl got=%b exp=0000", {char_in_vld, load_state, eop, ing.in_ready}); end
        n_vec++; if ({stream_id, enable} !== 14'd0) begin n_miss++; $display("FAIL rmid_sid_en got=%h exp=0", {stream_id, enable}); end
        ing.in_vld = 0; ing.in_sop = 0;
        @(posedge clk); #1; rst = 1'b0;
        repeat (10) @(posedge clk); #1;
        n_vec++; if (n_eop !== 0) begin n_miss++; $display("FAIL rmid_no_eop got=%0d exp=0", n_eop); end
        pb[0] = 8'h77;
        one_pkt(32'h44444444, 1);
        n_vec++; if ({ld_new, ld_sid} !== {1'b1, 6'd0}) begin n_miss++; $display("FAIL rmid_realloc got=%b/%0d exp=1/0", ld_new, ld_sid); end
        n_vec++; if (load_cyc - sop_cyc !== 2) begin n_miss++; $display("FAIL rmid_latency got=%0d exp=2", load_cyc - sop_cyc); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0; @(posedge clk); #1;
        pb[0] = 8'h42;
        for (int i = 0; i < 64; i++) begin
            one_pkt(32'h1000 + i, 1);
            n_vec++; if ({ld_new, ld_sid} !== {1'b1, 6'(i)}) begin n_miss++; $display("FAIL wrap_alloc[%0d] got=%b/%0d exp=1/%0d", i, ld_new, ld_sid, i); end
        end
        one_pkt(32'h1000 + 63, 1);
        n_vec++; if ({ld_new, ld_sid} !== {1'b0, 6'd63} || load_cyc - sop_cyc !== 65) begin n_miss++; $display("FAIL wrap_hit_last got=%b/%0d lat=%0d exp=0/63 lat=65", ld_new, ld_sid, load_cyc - sop_cyc); end
        one_pkt(32'h1000 + 64, 1);
        n_vec++; if ({ld_new, ld_sid} !== {1'b1, 6'd0} || load_cyc - sop_cyc !== 66) begin n_miss++; $display("FAIL wrap_65th got=%b/%0d lat=%0d exp=1/0 lat=66", ld_new, ld_sid, load_cyc - sop_cyc); end
        one_pkt(32'h1000, 1);
        n_vec++; if ({ld_new, ld_sid} !== {1'b1, 6'd1} || load_cyc - sop_cyc !== 66) begin n_miss++; $display("FAIL wrap_evicted got=%b/%0d lat=%0d exp=1/1 lat=66", ld_new, ld_sid, load_cyc - sop_cyc); end
    endtask

    initial begin
        test_reset();
        test_first_packet();
        test_hit();
        test_enable();
        test_backpressure();
        test_drop();
        test_reset_mid();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/dpi_stream_sequencer.md
# dpi_stream_sequencer

Feeds the per-regex DPI matcher bank from an incoming packet byte stream. For each packet it resolves a 32-bit flow key to a 6-bit stream id through a sequentially scanned stream table. It then drives the matcher-side protocol for the whole bank: `load_state`/`new_stream_id`/`stream_id`, the `char_in`/`char_in_vld` byte stream, per-regex `enable`, and a final `eop`. It sits between the packet ingress FIFO and the bank of matcher wrappers, and inserts the pipeline gaps those wrappers need.

## Interface
- `NUM_STREAMS`, 64: stream table depth; ids are 6 bits.
- `KEY_W`, 32: flow key width.
- `NUM_REGEX`, 8: matcher wrappers in the bank; one enable bit each.
- `LOAD_GAP`, 2: cycles from `load_state` to the first `char_in_vld`; minimum 2.
- `EOP_GAP`, 4: cycles from the last `char_in_vld` to `eop`; minimum 4.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_data` in 8: packet byte.
- `in_key` in KEY_W: flow key, valid on the sop beat.
- `in_vld` in 1: beat valid.
- `in_sop` in 1: first beat of packet.
- `in_eop` in 1: last beat of packet.
- `in_ready` out 1: beat accepted when `in_vld & in_ready`.
- `cfg_we` in 1: enable-table write strobe.
- `cfg_addr` in 6: enable-table index.
- `cfg_data` in NUM_REGEX: enable-table write data.
- `load_state` out 1: one-cycle pulse that starts a packet at the matchers.
- `new_stream_id` out 1: qualifies `load_state`; the stream was just allocated.
- `stream_id` out 6: current stream; held from `load_state` through `eop`.
- `enable` out NUM_REGEX: per-regex enable; held from `load_state` through `eop`.
- `char_in` out 8: byte to the matchers.
- `char_in_vld` out 1: `char_in` valid.
- `eop` out 1: one-cycle end-of-packet pulse.
- `drop_count` out 16: saturating count of discarded non-sop beats seen in IDLE.

## Operation
- **IDLE**: `in_ready = in_vld & ~in_sop`, so stray beats are discarded and `drop_count` increments, saturating at 0xFFFF. On `in_vld & in_sop` the block captures `in_key` without accepting the beat, then goes to LOOKUP.
- **LOOKUP**: compares one table entry per cycle, indices 0..`valid_cnt`-1.
  - Hit at index i: `stream_id = i`, `new = 0`.
  - Miss (or empty table): writes the key at `alloc_ptr` and sets its valid bit. `stream_id = alloc_ptr`, `new = 1`. `alloc_ptr` increments and wraps 63→0.
  - `valid_cnt` saturates at 64. When the table is full, a miss overwrites the oldest entry (FIFO replacement).
  - Then goes to LOAD.
- **LOAD**: pulses `load_state` for one cycle with `new_stream_id` and `stream_id`. It latches `enable <= en_table[stream_id]`, then goes to GAP.
- **GAP**: waits LOAD_GAP-1 cycles, then goes to STREAM.
- **STREAM**: `in_ready = 1`. Each accepted beat registers `char_in <= in_data` and `char_in_vld <= 1` the next cycle; `char_in_vld` is 0 otherwise. The sop beat is the first char. Accepting a beat with `in_eop` moves to DRAIN. An `in_sop` beat arriving in STREAM is treated as data; the packet framing error is not corrected.
- **DRAIN**: waits EOP_GAP cycles after the last char, with `in_ready = 0`.
- **EOP**: pulses `eop` for one cycle, then returns to IDLE. The next `load_state` is therefore at least 2 cycles after `eop`.
- **Enable table**:
  - Written by `cfg_we` in any state; the write takes effect the next cycle.
  - The enable value for the current packet is latched at LOAD, so writes during a packet do not change `enable` until the next LOAD.
  - A cfg write to the same id in the LOAD cycle is not seen; the LOAD uses the old value.

## Timing
- **Reset**: all outputs are 0, except `enable`, which is 0 until the first LOAD. Valid bits are cleared, `alloc_ptr` and `valid_cnt` are 0, the FSM is in IDLE, and `en_table` is all ones.
- **Reset mid-packet**: aborts immediately. No `eop` is issued, and the table contents are lost.
- **Lookup latency**: hit at index i takes i+1 cycles; miss takes `valid_cnt`+1 cycles (1 cycle when the table is empty).
- **sop to `load_state`**: lookup latency + 1 cycle.
- **First `char_in_vld`**: exactly LOAD_GAP cycles after `load_state`.
- **Last char to `eop`**: `eop` asserts exactly EOP_GAP cycles after the last `char_in_vld`. `load_state` and `eop` are never asserted together.

## Test plan
- **Empty table, first packet**: key 0xA5A5A5A5, 3 bytes "abc". Expect `load_state` with `new_stream_id = 1`, `stream_id = 0`. Chars at LOAD+2, +3, +4; `eop` 4 cycles after "c"; `enable = 0xFF`.
- **Hit**: repeat the same key after 2 other keys. Expect lookup of 1 cycle, `new_stream_id = 0`, `stream_id = 0`.
- **Wrap and replacement**: send 65 distinct keys. The 65th gets `stream_id = 0` with `new = 1`. Resending the first key then misses and allocates id 1.
- **Enable latching**:
  - Write `cfg_addr = 3`, `cfg_data = 0x05`; the next packet on id 3 shows `enable = 0x05`.
  - A write of 0x00 mid-packet leaves `enable = 0x05` until `eop`.
- **Backpressure and gaps**:
  - `in_vld` toggling 1/0 gives `char_in_vld` gaps that mirror the input.
  - Non-sop beats in IDLE increment `drop_count` (3 stray beats give 3).
- **Reset**: assert `rst` in STREAM. Outputs go to 0 asynchronously; after release, a re-sent key gets `new_stream_id = 1` and id 0.
